meter_display: RTL



---
 rtl/meter_display.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/meter_display.sv
// meter_display: scans four BCD digits onto a common-anode 7-segment display.
// Segments and anodes are active-low. Mode selects steady, 0.5 Hz blink,
// 1 Hz blink or off. Leading zeros can optionally be blanked.
module meter_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int HALF_DIV    = 50000000,
   parameter bit LZ_SUPPRESS = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic [3:0] digit3,
   input  logic [3:0] digit4,
   input  logic [1:0] mode,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int HW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [RW-1:0] REFRESH_ONE  = RW'(1);
   localparam logic [HW-1:0] HALF_LAST    = HW'(HALF_DIV - 1);
   localparam logic [HW-1:0] HALF_ONE     = HW'(1);

   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   logic [RW-1:0] refresh_cnt;
   logic [1:0]    scan_idx;
   logic          refresh_wrap;

   logic [HW-1:0] half_cnt;
   logic [HW-1:0] half_nxt;
   logic          half_tick;
   logic          sub_bit;
   logic          sub_nxt;
   logic          phase_on;
   logic          phase_nxt;
   logic [1:0]    mode_q;
   logic          mode_chg;

   logic          blank4;
   logic          blank3;
   logic          blank2;
   logic [3:0]    digit_sel_p0;
   logic [3:0]    an_sel_p0;
   logic          blank_sel_p0;
   logic          show_p0;
   logic [3:0]    an_p0;
   logic [6:0]    seg_p0;
   logic [3:0]    an_p1;
   logic [6:0]    seg_p1;

   assign refresh_wrap = (refresh_cnt == REFRESH_LAST);
   assign half_tick    = (half_cnt == HALF_LAST);
   // mode_q holds last cycle's mode, so a mismatch marks a mode change now.
   assign mode_chg     = (mode != mode_q);

   // Refresh divider: advance the scanned digit once per REFRESH_DIV cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt <= '0;
         scan_idx    <= 2'd0;
      end else if (refresh_wrap) begin
         refresh_cnt <= '0;
         scan_idx    <= scan_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + REFRESH_ONE;
      end
   end

   // Blink next-state: a mode change restarts the blink cadence in the ON phase.
   always_comb begin
      half_nxt  = half_tick ? '0 : (half_cnt + HALF_ONE);
      sub_nxt   = sub_bit;
      phase_nxt = phase_on;
      if (mode_chg) begin
         half_nxt  = '0;
         sub_nxt   = 1'b0;
         phase_nxt = 1'b1;
      end else begin
         case (mode)
            2'd3: begin
               if (half_tick) phase_nxt = ~phase_on;
            end
            2'd2: begin
               if (half_tick) begin
                  sub_nxt = ~sub_bit;
                  if (sub_bit) phase_nxt = ~phase_on;
               end
            end
            default: phase_nxt = 1'b1;
         endcase
      end
   end

   // Blink state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         half_cnt <= '0;
         sub_bit  <= 1'b0;
         phase_on <= 1'b1;
         mode_q   <= 2'd0;
      end else begin
         half_cnt <= half_nxt;
         sub_bit  <= sub_nxt;
         phase_on <= phase_nxt;
         mode_q   <= mode;
      end
   end

   // Stage p0: pick the scanned digit and apply leading-zero, mode and phase blanking.
   always_comb begin
      blank4       = LZ_SUPPRESS && (digit4 == 4'd0);
      blank3       = blank4 && (digit3 == 4'd0);
      blank2       = blank3 && (digit2 == 4'd0);
      digit_sel_p0 = digit1;
      an_sel_p0    = 4'b1110;
      blank_sel_p0 = 1'b0;
      case (scan_idx)
         2'd1: begin
            digit_sel_p0 = digit2;
            an_sel_p0    = 4'b1101;
            blank_sel_p0 = blank2;
         end
         2'd2: begin
            digit_sel_p0 = digit3;
            an_sel_p0    = 4'b1011;
            blank_sel_p0 = blank3;
         end
         2'd3: begin
            digit_sel_p0 = digit4;
            an_sel_p0    = 4'b0111;
            blank_sel_p0 = blank4;
         end
         default: ;
      endcase
      show_p0 = phase_on && (mode != 2'd0) && !blank_sel_p0;
      an_p0   = show_p0 ? an_sel_p0 : AN_OFF;
      seg_p0  = show_p0 ? bcd_to_seg(digit_sel_p0) : SEG_OFF;
   end

   // Stage p1: registered display drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_p1  <= AN_OFF;
         seg_p1 <= SEG_OFF;
      end else begin
         an_p1  <= an_p0;
         seg_p1 <= seg_p0;
      end
   end

   assign an  = an_p1;
   assign seg = seg_p1;
   assign dp  = 1'b1;

endmodule
